// File: rtl/alu_sequencer.sv
// CHIP-8 8XYn sequencer: runs LD/OR/AND/XOR locally and hands ADD to the alu,
// then writes Vx (and VF for ADD) back to the register file.
package alu_pkg;
  typedef enum logic [2:0] {
    ADD    = 3'd0,
    SUB    = 3'd1,
    AND_OP = 3'd2,
    OR_OP  = 3'd3,
    XOR_OP = 3'd4
  } alu_op_e;

  typedef struct packed {
    alu_op_e    op;
    logic [7:0] operand_a;
    logic [7:0] operand_b;
  } alu_input;
endpackage

module alu_sequencer
  import alu_pkg::*;
#(
  parameter int         ALU_TIMEOUT = 16,
  parameter logic [3:0] VF_ADDR     = 4'hF
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       start_in,
  input  logic [15:0] opcode_in,
  input  logic [7:0] vx_in,
  input  logic [7:0] vy_in,
  output logic       busy_out,
  output logic       done_out,
  output logic       illegal_out,
  output logic       timeout_out,
  output logic       wr_en_out,
  output logic [3:0] wr_addr_out,
  output logic [7:0] wr_data_out,
  output logic       alu_rst_out,
  output alu_input   alu_in_out,
  input  logic [7:0] alu_result_in,
  input  logic       alu_overflow_in,
  input  logic       alu_done_in
);

  localparam int CW = $clog2(ALU_TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    ALU_WAIT = 3'd1,
    WB_VX    = 3'd2,
    WB_VF    = 3'd3,
    FINISH   = 3'd4
  } state_e;

  state_e        state, state_nxt;
  logic [3:0]    x_q;
  logic          add_q;
  logic [7:0]    vx_q, vy_q, result_q;
  logic          carry_q;
  logic [CW-1:0] cnt_q;
  logic          illegal_q, timeout_q;

  logic          start_illegal, start_add, cnt_last;
  logic [7:0]    local_res;

  // Operand nibbles [7:4] carry the Y index, which the regfile has already resolved.
  logic unused_opcode_bits;
  assign unused_opcode_bits = ^opcode_in[7:4];

  assign start_illegal = (opcode_in[15:12] != 4'h8) || (opcode_in[3:0] > 4'h4);
  assign start_add     = (opcode_in[3:0] == 4'h4);
  assign cnt_last      = (cnt_q == CW'(ALU_TIMEOUT - 1));

  always_comb begin
    local_res = vy_in;
    case (opcode_in[1:0])
      2'd0:    local_res = vy_in;
      2'd1:    local_res = vx_in | vy_in;
      2'd2:    local_res = vx_in & vy_in;
      default: local_res = vx_in ^ vy_in;
    endcase
  end

  // start_in is a request with no ready: it is accepted only on an edge where
  // busy_out is low, and dropped otherwise.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start_in) begin
          if (start_illegal)  state_nxt = FINISH;
          else if (start_add) state_nxt = ALU_WAIT;
          else                state_nxt = WB_VX;
        end
      end
      ALU_WAIT: begin
        if (alu_done_in)   state_nxt = WB_VX;
        else if (cnt_last) state_nxt = FINISH;
      end
      WB_VX:   state_nxt = add_q ? WB_VF : FINISH;
      WB_VF:   state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_q       <= '0;
      add_q     <= 1'b0;
      vx_q      <= '0;
      vy_q      <= '0;
      result_q  <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_in) begin
            x_q       <= opcode_in[11:8];
            add_q     <= start_add && !start_illegal;
            vx_q      <= vx_in;
            vy_q      <= vy_in;
            result_q  <= local_res;
            carry_q   <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= start_illegal;
            timeout_q <= 1'b0;
          end
        end
        ALU_WAIT: begin
          cnt_q <= cnt_q + CW'(1);
          if (alu_done_in) begin
            result_q <= alu_result_in;
            carry_q  <= alu_overflow_in;
          end else if (cnt_last) begin
            timeout_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // All outputs decode the state register, so async reset clears them at once.
  always_comb begin
    busy_out    = (state != IDLE);
    done_out    = (state == FINISH);
    illegal_out = (state == FINISH) && illegal_q;
    timeout_out = (state == FINISH) && timeout_q;
    wr_en_out   = 1'b0;
    wr_addr_out = '0;
    wr_data_out = '0;
    alu_rst_out = (state != ALU_WAIT);
    alu_in_out  = '{op: ADD, operand_a: 8'h00, operand_b: 8'h00};
    case (state)
      ALU_WAIT: alu_in_out = '{op: ADD, operand_a: vx_q, operand_b: vy_q};
      WB_VX: begin
        wr_en_out   = 1'b1;
        wr_addr_out = x_q;
        wr_data_out = result_q;
      end
      WB_VF: begin
        wr_en_out   = 1'b1;
        wr_addr_out = VF_ADDR;
        wr_data_out = {7'b0, carry_q};
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural alu stand-in, write scoreboard and a
// spec-level reference model of results, flags and cycle latency.
module tb_alu_sequencer;
  import alu_pkg::*;

  localparam int ALU_TIMEOUT = 16;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic [15:0] opcode_in;
  logic [7:0]  vx_in, vy_in;
  logic        busy_out, done_out, illegal_out, timeout_out;
  logic        wr_en_out;
  logic [3:0]  wr_addr_out;
  logic [7:0]  wr_data_out;
  logic        alu_rst_out;
  alu_input    alu_in_out;
  logic [7:0]  alu_result_in;
  logic        alu_overflow_in;
  logic        alu_done_in;

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk_in = ~clk_in;

  alu_sequencer #(.ALU_TIMEOUT(ALU_TIMEOUT), .VF_ADDR(4'hF)) dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .start_in        (start_in),
    .opcode_in       (opcode_in),
    .vx_in           (vx_in),
    .vy_in           (vy_in),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .illegal_out     (illegal_out),
    .timeout_out     (timeout_out),
    .wr_en_out       (wr_en_out),
    .wr_addr_out     (wr_addr_out),
    .wr_data_out     (wr_data_out),
    .alu_rst_out     (alu_rst_out),
    .alu_in_out      (alu_in_out),
    .alu_result_in   (alu_result_in),
    .alu_overflow_in (alu_overflow_in),
    .alu_done_in     (alu_done_in)
  );

  // ---------------- alu stand-in ----------------
  // Sticky done raised alu_lat edges after its reset is released.
  int alu_lat = 2;
  bit alu_tie = 1'b0;
  int alu_cnt;
  always @(posedge clk_in) begin
    if (alu_rst_out) begin
      alu_cnt         <= 0;
      alu_done_in     <= 1'b0;
      alu_result_in   <= 8'h00;
      alu_overflow_in <= 1'b0;
    end else if (!alu_tie) begin
      alu_cnt <= alu_cnt + 1;
      if (alu_cnt + 1 == alu_lat) begin
        alu_done_in <= 1'b1;
        {alu_overflow_in, alu_result_in} <= 9'(alu_in_out.operand_a) + 9'(alu_in_out.operand_b);
      end
    end
  end

  // ---------------- write scoreboard ----------------
  always @(negedge clk_in) begin : sb
    logic [11:0] e;
    if (rst_in && wr_en_out) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", wr_addr_out, wr_data_out);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr_out, wr_data_out} !== e) begin
          n_fail++;
          $display("FAIL wr_data: got addr=%h data=%h, expected addr=%h data=%h",
                   wr_addr_out, wr_data_out, e[11:8], e[7:0]);
        end
      end
    end
  end

  // ---------------- driver + reference model ----------------
  task automatic run_op(input logic [15:0] op, input logic [7:0] vx, input logic [7:0] vy,
                        input int lat, input bit tie, input bit pulse_busy);
    bit         e_ill, e_tmo, alu_bad, busy_bad;
    int         e_cyc, e_low, cyc, low, seen;
    logic [8:0] sum;
    logic [7:0] r;
    alu_input   e_ai;
    e_ill = 0; e_tmo = 0; e_low = 0;
    e_ai  = '{op: ADD, operand_a: vx, operand_b: vy};
    if (op[15:12] != 4'h8 || op[3:0] > 4'h4) begin
      e_ill = 1; e_cyc = 1;
    end else if (op[3:0] < 4'h4) begin
      case (op[1:0])
        2'd0:    r = vy;
        2'd1:    r = vx | vy;
        2'd2:    r = vx & vy;
        default: r = vx ^ vy;
      endcase
      exp_q.push_back({op[11:8], r});
      e_cyc = 2;
    end else begin
      seen = lat + 1;
      if (!tie && seen <= ALU_TIMEOUT) begin
        sum = 9'(vx) + 9'(vy);
        exp_q.push_back({op[11:8], sum[7:0]});
        exp_q.push_back({4'hF, 7'b0, sum[8]});
        e_cyc = seen + 3; e_low = seen;
      end else begin
        e_tmo = 1; e_cyc = ALU_TIMEOUT + 1; e_low = ALU_TIMEOUT;
      end
    end

    alu_lat = lat; alu_tie = tie;
    start_in = 1'b1; opcode_in = op; vx_in = vx; vy_in = vy;
    @(posedge clk_in);
    cyc = 1; low = 0; alu_bad = 0; busy_bad = 0;
    @(negedge clk_in);
    if (pulse_busy) begin
      opcode_in = 16'h8000 | 16'($urandom_range(0, 4)); vx_in = 8'($urandom); vy_in = 8'($urandom);
    end else start_in = 1'b0;
    while (!done_out && cyc < 60) begin
      if (!alu_rst_out) begin
        low++;
        if (alu_in_out !== e_ai) alu_bad = 1;
      end
      if (!busy_out) busy_bad = 1;
      @(posedge clk_in); cyc++;
      @(negedge clk_in); start_in = 1'b0;
    end

    n_checks++;
    if (cyc !== e_cyc || done_out !== 1'b1) begin
      n_fail++; $display("FAIL done_latency op=%h: got %0d cycles done=%b, expected %0d", op, cyc, done_out, e_cyc);
    end
    n_checks++;
    if (illegal_out !== e_ill) begin
      n_fail++; $display("FAIL illegal_flag op=%h: got %b expected %b", op, illegal_out, e_ill);
    end
    n_checks++;
    if (timeout_out !== e_tmo) begin
      n_fail++; $display("FAIL timeout_flag op=%h: got %b expected %b", op, timeout_out, e_tmo);
    end
    n_checks++;
    if (low !== e_low) begin
      n_fail++; $display("FAIL alu_rst_low op=%h: got %0d cycles expected %0d", op, low, e_low);
    end
    n_checks++;
    if (alu_bad || busy_bad) begin
      n_fail++; $display("FAIL alu_bus_busy op=%h: got alu_bad=%b busy_bad=%b expected 0/0", op, alu_bad, busy_bad);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL missing_writes op=%h: got %0d pending expected 0", op, exp_q.size());
      exp_q.delete();
    end
    @(posedge clk_in);
    @(negedge clk_in); start_in = 1'b0;
    n_checks++;
    if (done_out !== 1'b0 || busy_out !== 1'b0) begin
      n_fail++; $display("FAIL done_pulse op=%h: got done=%b busy=%b expected 0/0", op, done_out, busy_out);
    end
  endtask

  // ---------------- tests ----------------
  task automatic check_idle_outputs(input string name);
    n_checks++;
    if (busy_out !== 1'b0 || done_out !== 1'b0 || illegal_out !== 1'b0 || timeout_out !== 1'b0 ||
        wr_en_out !== 1'b0 || wr_addr_out !== 4'h0 || wr_data_out !== 8'h00 ||
        alu_rst_out !== 1'b1 || alu_in_out !== 19'h0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b ill=%b tmo=%b wr=%b/%h/%h alu_rst=%b alu_in=%h, expected all 0 with alu_rst=1",
               name, busy_out, done_out, illegal_out, timeout_out, wr_en_out, wr_addr_out, wr_data_out,
               alu_rst_out, alu_in_out);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0; start_in = 1'b0; opcode_in = '0; vx_in = '0; vy_in = '0;
    repeat (3) @(negedge clk_in);
    check_idle_outputs("reset_state");
    rst_in = 1'b1;
    @(negedge clk_in);
    check_idle_outputs("idle_after_reset");
  endtask

  task automatic test_spec_add();
    run_op(16'h8124, 8'h10, 8'h20, 2, 0, 0);
    run_op(16'h8AB4, 8'hFF, 8'h01, 2, 0, 0);
    run_op(16'h8F04, 8'hF0, 8'h20, 2, 0, 0);
  endtask

  task automatic test_local();
    run_op(16'h8342, 8'hF0, 8'h3C, 2, 0, 0);
    run_op(16'h8010, 8'h5A, 8'hC3, 2, 0, 0);
    run_op(16'h8561, 8'h0F, 8'hA0, 2, 0, 0);
    run_op(16'h8F73, 8'hFF, 8'h0F, 2, 0, 0);
  endtask

  task automatic test_illegal();
    run_op(16'h8125, 8'h11, 8'h22, 2, 0, 1);
    run_op(16'h1234, 8'h11, 8'h22, 2, 0, 1);
    run_op(16'hF00E, 8'h00, 8'h00, 2, 0, 0);
  endtask

  task automatic test_timeout();
    run_op(16'h8124, 8'h10, 8'h20, 2, 1, 0);
    run_op(16'h8124, 8'h80, 8'h90, ALU_TIMEOUT - 1, 0, 0);
    run_op(16'h8124, 8'h80, 8'h90, ALU_TIMEOUT, 0, 0);
  endtask

  task automatic test_mid_reset();
    int dones;
    alu_tie = 1'b1;
    start_in = 1'b1; opcode_in = 16'h8124; vx_in = 8'h10; vy_in = 8'h20;
    @(posedge clk_in);
    @(negedge clk_in); start_in = 1'b0;
    repeat (4) @(negedge clk_in);
    #2 rst_in = 1'b0;
    #1 check_idle_outputs("async_reset_mid_alu_wait");
    @(negedge clk_in); rst_in = 1'b1;
    dones = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (done_out || busy_out || wr_en_out) dones++;
    end
    n_checks++;
    if (dones !== 0) begin
      n_fail++; $display("FAIL abort_no_done: got %0d active cycles expected 0", dones);
    end
    alu_tie = 1'b0;
  endtask

  task automatic test_back_to_back_random();
    logic [15:0] op;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 7) == 0) op = 16'($urandom);
      else op = {4'h8, 4'($urandom), 4'($urandom), 4'($urandom_range(0, 5))};
      run_op(op, 8'($urandom), 8'($urandom),
             ($urandom_range(0, 5) == 0) ? $urandom_range(14, 17) : $urandom_range(1, 6),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) == 0));
    end
  endtask

  initial begin
    test_reset();
    test_spec_add();
    test_local();
    test_illegal();
    test_timeout();
    test_mid_reset();
    test_back_to_back_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule
